// File: rtl/lcd_menu_seq_pkg.sv
// lcd_menu_pkg: LCD command constants, sequencer states and the menu text table.
package lcd_menu_pkg;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_LINE1 = 8'h80;
  localparam logic [7:0] CMD_LINE2 = 8'hC0;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2, S_FINISH} state_t;
  // Strings are right-aligned in s, so len locates the first character; pages without text read as blanks.
  function automatic logic [7:0] menu_char(input int page, input logic line, input int col);
    logic [127:0] s;
    int len;
    s = '0;
    len = 0;
    case (page * 2 + int'(line))
      0: begin s = "MAIN MENU"; len = 9; end
      1: begin s = "UP/DN TO BROWSE"; len = 15; end
      2: begin s = "STATUS"; len = 6; end
      3: begin s = "ALL SYSTEMS OK"; len = 14; end
      4: begin s = "SETTINGS"; len = 8; end
      5: begin s = "CONTRAST 50%"; len = 12; end
      6: begin s = "ABOUT"; len = 5; end
      7: begin s = "LCD MENU V1.0"; len = 13; end
      default: begin s = '0; len = 0; end
    endcase
    return col < len ? s[8 * (len - 1 - col) +: 8] : 8'h20;
  endfunction
endpackage

// File: rtl/lcd_menu_seq_if.sv
// lcd_menu_seq_if: command/data handshake between the menu sequencer and the LCD timing driver.
interface lcd_menu_seq_if;
  logic [7:0] dbi;
  logic       wr;
  logic [7:0] direc;
  logic       dr;
  logic       ack;
  modport master(output dbi, wr, direc, dr, input ack);
  modport slave(input dbi, wr, direc, dr, output ack);
endinterface

// File: rtl/lcd_menu_seq_rom.sv
// lcd_menu_rom: combinational character lookup into the menu text table.
module lcd_menu_rom import lcd_menu_pkg::*; #(
  parameter int PW = 2,
  parameter int CW = 4
) (
  input  logic [PW-1:0] page_i,
  input  logic          line_i,
  input  logic [CW-1:0] col_i,
  output logic [7:0]    ch_o
);
  always_comb ch_o = menu_char(int'(page_i), line_i, int'(col_i));
endmodule

// File: rtl/lcd_menu_seq.sv
// lcd_menu_seq: multi-page two-line LCD menu writer with wrap-around navigation and ack back-pressure.
module lcd_menu_seq import lcd_menu_pkg::*; #(
  parameter int         N_PAGES      = 4,
  parameter int         LINE_CHARS   = 16,
  parameter logic [7:0] LINE1_ADDR   = CMD_LINE1,
  parameter logic [7:0] LINE2_ADDR   = CMD_LINE2,
  parameter bit         POWERUP_DRAW = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wrmenu,
  input  logic                       up,
  input  logic                       down,
  lcd_menu_seq_if.master             lcd,
  output logic [$clog2(N_PAGES)-1:0] page,
  output logic                       menu_busy,
  output logic                       done
);
  localparam int PW = $clog2(N_PAGES);
  localparam int CW = LINE_CHARS > 1 ? $clog2(LINE_CHARS) : 1;
  localparam logic [PW-1:0] LAST_PAGE = PW'(N_PAGES - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(LINE_CHARS - 1);
  state_t state_q, state_d;
  logic [PW-1:0] page_q, page_d;
  logic [CW-1:0] col_q, col_d;
  logic pwr_q, pwr_d;
  logic [7:0] ch;
  lcd_menu_rom #(.PW(PW), .CW(CW)) u_rom (
    .page_i(page_q),
    .line_i(state_q == S_LINE2),
    .col_i (col_q),
    .ch_o  (ch)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      page_q  <= '0;
      col_q   <= '0;
      pwr_q   <= POWERUP_DRAW;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      col_q   <= col_d;
      pwr_q   <= pwr_d;
    end
  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    col_d     = col_q;
    pwr_d     = pwr_q;
    lcd.wr    = 1'b0;
    lcd.dr    = 1'b0;
    lcd.dbi   = 8'h00;
    lcd.direc = 8'h00;
    page      = page_q;
    menu_busy = state_q != S_IDLE;
    done      = state_q == S_FINISH;
    case (state_q)
      S_IDLE:
        if (pwr_q) begin
          pwr_d   = 1'b0;
          state_d = S_CLEAR;
        end else if (up ^ down) begin
          page_d  = up ? (page_q == LAST_PAGE ? '0 : page_q + 1'b1)
                       : (page_q == '0 ? LAST_PAGE : page_q - 1'b1);
          state_d = S_CLEAR;
        end else if (wrmenu && !up && !down) state_d = S_CLEAR;
      S_CLEAR: begin
        lcd.dr    = 1'b1;
        lcd.direc = CMD_CLEAR;
        state_d   = lcd.ack ? S_ADDR1 : S_CLEAR;
      end
      S_ADDR1, S_ADDR2: begin
        lcd.dr    = 1'b1;
        lcd.direc = state_q == S_ADDR1 ? LINE1_ADDR : LINE2_ADDR;
        col_d     = lcd.ack ? '0 : col_q;
        state_d   = !lcd.ack ? state_q : state_q == S_ADDR1 ? S_LINE1 : S_LINE2;
      end
      S_LINE1, S_LINE2: begin
        lcd.wr  = 1'b1;
        lcd.dbi = ch;
        if (lcd.ack) begin
          col_d   = col_q == LAST_COL ? col_q : col_q + 1'b1;
          state_d = col_q != LAST_COL ? state_q : state_q == S_LINE1 ? S_ADDR2 : S_FINISH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_lcd_menu_seq.sv
// tb_lcd_menu_seq: randomized navigation/back-pressure bench against a string-table reference model.
module tb_lcd_menu_seq;
  localparam int NP = 4;
  localparam int LC = 16;
  typedef logic [8:0] tq_t[$];
  logic clk = 1'b0, rst = 1'b0, wrmenu = 1'b0, up = 1'b0, down = 1'b0;
  logic [1:0] page;
  logic menu_busy, done;
  int n_cmp = 0, n_bad = 0;
  string txt[NP][2] = '{'{"MAIN MENU", "UP/DN TO BROWSE"}, '{"STATUS", "ALL SYSTEMS OK"},
                        '{"SETTINGS", "CONTRAST 50%"}, '{"ABOUT", "LCD MENU V1.0"}};
  lcd_menu_seq_if lcd();
  lcd_menu_seq #(.N_PAGES(NP), .LINE_CHARS(LC), .LINE1_ADDR(8'h80), .LINE2_ADDR(8'hC0), .POWERUP_DRAW(1)) dut (
    .clk(clk), .rst(rst), .wrmenu(wrmenu), .up(up), .down(down),
    .lcd(lcd.master), .page(page), .menu_busy(menu_busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] ch(input int p, input int l, input int c);
    return c < txt[p][l].len() ? txt[p][l][c] : 8'h20;
  endfunction
  // Expected accepted transactions as {is_command, byte}.
  function automatic tq_t stream(input int p);
    tq_t q;
    q.push_back(9'h101);
    q.push_back(9'h180);
    for (int c = 0; c < LC; c++) q.push_back({1'b0, ch(p, 0, c)});
    q.push_back(9'h1C0);
    for (int c = 0; c < LC; c++) q.push_back({1'b0, ch(p, 1, c)});
    return q;
  endfunction
  task automatic pulse(input bit u, input bit d, input bit w);
    up = u; down = d; wrmenu = w;
    step();
    up = 0; down = 0; wrmenu = 0;
  endtask
  // mode 0: ack always high, 1: random ack, 2: ack low for 10 cycles then random.
  task automatic run_redraw(input int p, input int mode, input int inj);
    tq_t exp, got;
    int k;
    bit fin, hold, a;
    logic [17:0] prev;
    exp = stream(p);
    k = 1; fin = 0; hold = 0; prev = '0;
    while (k <= 2000 && !fin) begin
      chk("busy", menu_busy, 1);
      chk("page", page, p);
      chk("wr_dr_excl", lcd.wr & lcd.dr, 0);
      if (hold) chk("hold", {lcd.wr, lcd.dr, lcd.dbi, lcd.direc}, prev);
      if (done) begin
        fin = 1;
        if (mode == 0) chk("done_cycle", k, 36);
        chk("n_xact", got.size(), exp.size());
      end else begin
        a = mode == 0 ? 1'b1 : (mode == 2 && k <= 10) ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (mode == 2 && k <= 10) chk("clear_held", {lcd.dr, lcd.direc}, 9'h101);
        lcd.ack = a;
        up = inj > 0 && k == inj;
        wrmenu = inj > 0 && k == inj + 3;
        if (a && (lcd.wr || lcd.dr)) got.push_back(lcd.dr ? {1'b1, lcd.direc} : {1'b0, lcd.dbi});
        hold = !a && (lcd.wr || lcd.dr);
        prev = {lcd.wr, lcd.dr, lcd.dbi, lcd.direc};
        step();
        k++;
      end
    end
    if (!fin) chk("timeout", 0, 1);
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("xact%0d", i), i < got.size() ? got[i] : 9'h000, exp[i]);
    lcd.ack = 1; up = 0; wrmenu = 0;
    step();
    chk("idle_busy", menu_busy, 0);
    chk("done_one_cycle", done, 0);
    chk("idle_req", lcd.wr | lcd.dr, 0);
  endtask
  task automatic check_idle(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      chk("stay_idle_busy", menu_busy, 0);
      chk("stay_idle_req", lcd.wr | lcd.dr, 0);
      chk("stay_idle_page", page, p);
      step();
    end
  endtask
  initial begin
    int p, kind, mode;
    lcd.ack = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_out", {lcd.wr, lcd.dr, lcd.dbi, lcd.direc, page, menu_busy, done}, 0);
    end
    rst = 1;
    step();
    run_redraw(0, 0, 0);
    pulse(0, 1, 0);
    run_redraw(3, 0, 0);
    pulse(1, 0, 0);
    run_redraw(0, 0, 0);
    pulse(1, 1, 0);
    check_idle(0, 5);
    pulse(0, 0, 1);
    run_redraw(0, 2, 0);
    pulse(1, 0, 0);
    run_redraw(1, 0, 5);
    pulse(0, 0, 1);
    run_redraw(1, 0, 0);
    pulse(1, 0, 0);
    run_redraw(2, 0, 0);
    pulse(0, 0, 1);
    for (int i = 0; i < 11; i++) step();
    chk("mid_wr", lcd.wr, 1);
    chk("mid_char", lcd.dbi, ch(2, 0, 9));
    rst = 0;
    #1;
    chk("async_rst", {lcd.wr, lcd.dr, lcd.dbi, lcd.direc, page, menu_busy, done}, 0);
    step();
    step();
    rst = 1;
    step();
    run_redraw(0, 0, 0);
    p = 0;
    for (int it = 0; it < 14; it++) begin
      kind = $urandom_range(0, 3);
      mode = $urandom_range(0, 2);
      lcd.ack = 1'($urandom_range(0, 1));
      pulse(kind == 0 || kind == 3, kind == 1 || kind == 3, kind == 2);
      if (kind == 3) check_idle(p, 3);
      else begin
        p = kind == 0 ? (p + 1) % NP : kind == 1 ? (p + NP - 1) % NP : p;
        run_redraw(p, mode, mode == 1 ? $urandom_range(3, 30) : 0);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
